// File: rtl/poly_input_loader_if.sv
// Word-wide valid/ready stream carrying operand words from the host/DMA
// side into the loader. The master drives data and valid, the slave
// (the loader) answers with ready.
interface poly_input_loader_if #(
   parameter int WORD_WIDTH = 17
);
   logic [WORD_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/poly_input_loader.sv
// Streams the AMNS operand registers A, B, M and M_prime_0 into the
// register bank, one stream word per enable pulse, least-significant
// word first. Registers not selected by the job mask are skipped.
module poly_input_loader #(
   parameter int WORD_WIDTH = 17,
   parameter int N          = 5,
   parameter int S          = 4
) (
   input  logic                  clock_i,
   input  logic                  reset_n_i,
   input  logic                  start_i,
   input  logic [3:0]            load_mask_i,
   input  logic                  abort_i,
   poly_input_loader_if.slave    s_if,
   output logic [1:0]            INPUT_reg_sel_o,
   output logic                  INPUT_reg_en_o,
   output logic [WORD_WIDTH-1:0] INPUT_reg_din_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int LONG_LEN = N * S;
   localparam int CNT_W    = $clog2(LONG_LEN);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      LOAD_M,
      LOAD_MP,
      DONE
   } state_t;

   state_t           state_q;
   state_t           first_state;
   state_t           after_state;
   logic [3:0]       mask_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] last_cnt;
   logic [1:0]       cur_code;
   logic             loading;
   logic             handshake;
   logic             last_word;

   // Load state for a bank register code (00 A, 01 B, 10 M, 11 M_prime_0).
   function automatic state_t load_state(input logic [1:0] code);
      unique case (code)
         2'd0:    return LOAD_A;
         2'd1:    return LOAD_B;
         2'd2:    return LOAD_M;
         default: return LOAD_MP;
      endcase
   endfunction

   // Lowest selected register at or above position 'from'; DONE if none.
   function automatic state_t pick(input logic [3:0] mask, input logic [2:0] from);
      state_t r;
      r = DONE;
      for (int i = 3; i >= 0; i--) begin
         if (mask[i] && (i >= int'(from))) r = load_state(2'(i));
      end
      return r;
   endfunction

   // Decode the current register, its last-word index and the successor state.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      loading  = 1'b0;
      cur_code = 2'd0;
      unique case (state_q)
         LOAD_A:  begin loading = 1'b1; cur_code = 2'd0; end
         LOAD_B:  begin loading = 1'b1; cur_code = 2'd1; end
         LOAD_M:  begin loading = 1'b1; cur_code = 2'd2; end
         LOAD_MP: begin loading = 1'b1; cur_code = 2'd3; end
         default: ;
      endcase
      last_cnt    = (state_q == LOAD_MP) ? CNT_W'(N - 1) : CNT_W'(LONG_LEN - 1);
      handshake   = loading & s_if.s_valid;
      last_word   = (cnt_q == last_cnt);
      first_state = pick(load_mask_i, 3'd0);
      after_state = pick(mask_q, {1'b0, cur_code} + 3'd1);
   end

   assign s_if.s_ready = loading;
   assign busy_o       = (state_q != IDLE);

   // Job sequencer: state, word counter and registered bank/done outputs.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q         <= IDLE;
         mask_q          <= 4'd0;
         cnt_q           <= '0;
         INPUT_reg_sel_o <= 2'd0;
         INPUT_reg_en_o  <= 1'b0;
         INPUT_reg_din_o <= '0;
         done_o          <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         INPUT_reg_en_o <= 1'b0;
         done_o         <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  mask_q  <= load_mask_i;
                  state_q <= first_state;
                  done_o  <= (first_state == DONE);
               end
            end
            LOAD_A, LOAD_B, LOAD_M, LOAD_MP: begin
               if (handshake) begin
                  INPUT_reg_en_o  <= 1'b1;
                  INPUT_reg_sel_o <= cur_code;
                  INPUT_reg_din_o <= s_if.s_data;
                  if (last_word) begin
                     cnt_q   <= '0;
                     state_q <= after_state;
                     done_o  <= (after_state == DONE);
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               // Abort overrides any transition; a word taken this cycle is still emitted.
               if (abort_i) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  done_o  <= 1'b0;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_input_loader.sv
// Self-checking bench for poly_input_loader: a queue-based job model
// predicts every output each cycle, and a shift-register bank model fed by
// the DUT outputs is compared against the source vectors after each job.
module tb_poly_input_loader;

   localparam int WW   = 17;
   localparam int N    = 5;
   localparam int S    = 4;
   localparam int LONG = N * S;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [3:0]    mask  = 4'd0;
   logic [1:0]    sel;
   logic          en;
   logic [WW-1:0] din;
   logic          busy;
   logic          done;

   poly_input_loader_if #(.WORD_WIDTH(WW)) s_if ();

   poly_input_loader #(.WORD_WIDTH(WW), .N(N), .S(S)) dut (
      .clock_i         (clk),
      .reset_n_i       (rst_n),
      .start_i         (start),
      .load_mask_i     (mask),
      .abort_i         (abort),
      .s_if            (s_if),
      .INPUT_reg_sel_o (sel),
      .INPUT_reg_en_o  (en),
      .INPUT_reg_din_o (din),
      .busy_o          (busy),
      .done_o          (done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int len_of(input int r);
      return (r == 3) ? N : LONG;
   endfunction

   // ---------------- reference model ----------------
   logic [WW-1:0] src  [4][LONG];
   logic [WW-1:0] bank [4][LONG];
   int            slots[$];          // register codes of words still owed by the job
   logic [WW-1:0] stream[$];         // words the source will present, in order
   bit            in_done  = 1'b0;
   bit            m_loading;
   bit            m_was_done;
   logic          exp_en   = 1'b0;
   logic          exp_done = 1'b0;
   logic [1:0]    exp_sel  = 2'd0;
   logic [WW-1:0] exp_din  = '0;
   int            hs_cnt   = 0;
   int            valid_pct = 100;

   // Job model: a start builds the list of owed words; each accepted word is
   // emitted next cycle; finishing the list yields a one-cycle done.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slots.delete();
         in_done  = 1'b0;
         exp_en   = 1'b0;
         exp_done = 1'b0;
         exp_sel  = 2'd0;
         exp_din  = '0;
      end else begin
         m_loading  = (slots.size() > 0);
         m_was_done = in_done;
         exp_en     = 1'b0;
         exp_done   = 1'b0;
         in_done    = 1'b0;
         if (m_loading) begin
            if (s_if.s_valid) begin
               exp_en  = 1'b1;
               exp_sel = 2'(slots.pop_front());
               exp_din = s_if.s_data;
               hs_cnt++;
               if (stream.size() > 0) void'(stream.pop_front());
            end
            if (abort) slots.delete();
            else if (slots.size() == 0) begin
               in_done  = 1'b1;
               exp_done = 1'b1;
            end
         end else if (!m_was_done && start) begin
            for (int r = 0; r < 4; r++)
               if (mask[r]) for (int k = 0; k < len_of(r); k++) slots.push_back(r);
            if (slots.size() == 0) begin
               in_done  = 1'b1;
               exp_done = 1'b1;
            end
         end
      end
   end

   // Bank model fed by the DUT: shift-in at the top so word 0 ends in slot 0.
   int bl;
   always @(posedge clk) begin
      if (rst_n && en) begin
         bl = len_of(int'(sel));
         for (int k = 0; k < bl - 1; k++) bank[sel][k] = bank[sel][k + 1];
         bank[sel][bl - 1] = din;
      end
   end

   // ---------------- per-cycle compare and statistics ----------------
   int cyc = 0, en_cnt = 0, done_cnt = 0, busy_cnt = 0, ready_cnt = 0;
   int last_en_cyc = 0, done_cyc = 0;
   int sel_cnt[4];

   always @(negedge clk) begin
      cyc++;
      check("cycle_outputs",
            {s_if.s_ready, busy, en, done, sel, din},
            {(slots.size() > 0), ((slots.size() > 0) || in_done), exp_en, exp_done, exp_sel, exp_din});
      if (en) begin
         en_cnt++;
         sel_cnt[sel]++;
         last_en_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (s_if.s_ready) ready_cnt++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_stats();
      en_cnt = 0; done_cnt = 0; busy_cnt = 0; ready_cnt = 0; hs_cnt = 0;
      last_en_cyc = 0; done_cyc = 0;
      for (int r = 0; r < 4; r++) sel_cnt[r] = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      s_if.s_valid = ($urandom_range(99) < valid_pct);
      s_if.s_data  = (stream.size() > 0) ? stream[0] : WW'($urandom);
   endtask

   task automatic randomize_src(input logic [3:0] m);
      for (int r = 0; r < 4; r++)
         if (m[r]) for (int k = 0; k < LONG; k++) src[r][k] = WW'($urandom);
   endtask

   task automatic load_stream(input logic [3:0] m);
      stream.delete();
      for (int r = 0; r < 4; r++)
         if (m[r]) for (int k = 0; k < len_of(r); k++) stream.push_back(src[r][k]);
   endtask

   task automatic begin_job(input logic [3:0] m, input int pct);
      load_stream(m);
      valid_pct = pct;
      clear_stats();
      mask  = m;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_job(input logic [3:0] m, input int pct, input string tag);
      int guard;
      int words;
      words = 0;
      for (int r = 0; r < 4; r++) if (m[r]) words += len_of(r);
      begin_job(m, pct);
      guard = 0;
      while (done_cnt == 0 && guard < 2000) begin
         step();
         guard++;
      end
      step();
      step();
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_en_pulses"}, en_cnt, words);
      if (m != 4'd0) check({tag, "_done_with_last_en"}, done_cyc, last_en_cyc);
      for (int r = 0; r < 4; r++)
         if (m[r]) for (int k = 0; k < len_of(r); k++)
            check($sformatf("%s_bank%0d_w%0d", tag, r, k), bank[r][k], src[r][k]);
   endtask

   // ---------------- test sequence ----------------
   logic [WW-1:0] save_a [LONG];
   logic [WW-1:0] save_m [LONG];

   initial begin
      int guard;
      int diffs;
      s_if.s_valid = 1'b0;
      s_if.s_data  = '0;
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < LONG; k++) bank[r][k] = '0;

      // Reset values
      #3;
      check("rst_ready", s_if.s_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_en", en, 0);
      check("rst_sel", sel, 0);
      check("rst_din", din, 0);
      check("rst_done", done, 0);
      #19 rst_n = 1'b1;

      // Full load, valid held high
      randomize_src(4'hF);
      run_job(4'hF, 100, "full");
      check("full_sel_a", sel_cnt[0], 20);
      check("full_sel_b", sel_cnt[1], 20);
      check("full_sel_m", sel_cnt[2], 20);
      check("full_sel_mp", sel_cnt[3], 5);
      check("full_busy_cycles", busy_cnt, 66);
      check("full_ready_cycles", ready_cnt, 65);

      // Backpressure, same source vectors
      run_job(4'hF, 50, "bp");
      check("bp_sel_mp", sel_cnt[3], 5);

      // Partial mask 1010: A and M must keep their contents
      for (int k = 0; k < LONG; k++) begin
         save_a[k] = bank[0][k];
         save_m[k] = bank[2][k];
      end
      randomize_src(4'b1010);
      run_job(4'b1010, 100, "m1010");
      diffs = 0;
      for (int k = 0; k < LONG; k++) begin
         if (bank[0][k] !== save_a[k]) diffs++;
         if (bank[2][k] !== save_m[k]) diffs++;
      end
      check("m1010_a_m_untouched", diffs, 0);
      check("m1010_ready_cycles", ready_cnt, 25);
      check("m1010_sel_a", sel_cnt[0], 0);
      check("m1010_sel_b", sel_cnt[1], 20);
      check("m1010_sel_mp", sel_cnt[3], 5);

      // Empty mask
      run_job(4'b0000, 100, "m0000");
      check("m0000_ready_cycles", ready_cnt, 0);
      check("m0000_busy_cycles", busy_cnt, 1);

      // Abort after 7 B words, with a start pulse during the load
      randomize_src(4'hF);
      begin_job(4'hF, 100);
      guard = 0;
      while (hs_cnt < 27 && guard < 200) begin
         step();
         guard++;
         if (hs_cnt == 10) begin
            start = 1'b1;
            mask  = 4'b0000;
         end else begin
            start = 1'b0;
            mask  = 4'hF;
         end
      end
      start = 1'b0;
      check("abort_reached_27", hs_cnt, 27);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy_low", busy, 0);
      check("abort_ready_low", s_if.s_ready, 0);
      check("abort_last_word_en", en, 1);
      check("abort_last_word_sel", sel, 1);
      repeat (5) step();
      check("abort_no_done", done_cnt, 0);
      check("abort_en_pulses", en_cnt, 28);
      stream.delete();
      run_job(4'hF, 100, "after_abort");

      // Asynchronous reset during the M load
      randomize_src(4'hF);
      begin_job(4'hF, 100);
      guard = 0;
      while (hs_cnt < 50 && guard < 200) begin
         step();
         guard++;
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready", s_if.s_ready, 0);
      check("arst_busy", busy, 0);
      check("arst_en", en, 0);
      check("arst_sel", sel, 0);
      check("arst_din", din, 0);
      check("arst_done", done, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      stream.delete();
      clear_stats();
      valid_pct = 100;
      repeat (5) step();
      check("idle_ignores_valid_en", en_cnt, 0);
      check("idle_ignores_valid_ready", ready_cnt, 0);
      check("arst_no_done", done_cnt, 0);
      randomize_src(4'hF);
      run_job(4'hF, 100, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
